movement_control: RTL and testbench

- Sequencing FSM directly upstream of the movement datapath. Generates its 4-bit control code and PorB object select.
- Once per frame it erases, moves and redraws each sprite: bird first, then player crosshair.
- Advances through CLEAR and DRAW on the datapath's one-cycle enable (draw-done) pulse. Snapshots direction requests at frame start.

---
 rtl/movement_control.sv | 219 +++++++++++++++++++++
 tb/tb_movement_control.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/movement_control.sv
`default_nettype none
// ============================================================================
// Module   : movement_control
// Purpose  : Per-frame sequencer for the movement datapath. Erases, moves and
//            redraws the bird and then the player crosshair once per frame
//            tick, driving the datapath control code and PorB object select.
// Revision : 1.0 - initial release
// ============================================================================
module movement_control #(
    parameter int FRAME_CYCLES = 833333,
    parameter int P_STEP       = 2,
    parameter int B_STEP       = 1,
    parameter int TIMEOUT      = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done,
    input  logic       p_left,
    input  logic       p_right,
    input  logic       p_up,
    input  logic       p_down,
    input  logic       b_left,
    input  logic       b_right,
    input  logic       b_up,
    input  logic       b_down,
    input  logic       bird_active,
    output logic [3:0] control,
    output logic       PorB,
    output logic       frame_start,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int c_FRAME_W = $clog2(FRAME_CYCLES);
    localparam int c_WAIT_W  = $clog2(TIMEOUT);

    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(FRAME_CYCLES - 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [2:0]           c_P_LAST     = 3'(P_STEP - 1);
    localparam logic [2:0]           c_B_LAST     = 3'(B_STEP - 1);

    // State encodings double as the datapath control codes.
    typedef enum logic [3:0] {
        S_PREHOLD = 4'b0100,
        S_HOLD    = 4'b0000,
        S_CLEAR   = 4'b0001,
        S_LEFT    = 4'b0011,
        S_RIGHT   = 4'b0010,
        S_DOWN    = 4'b0110,
        S_UP      = 4'b0111,
        S_DRAW    = 4'b0101
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_FRAME_W-1:0]   r_frame_cnt;
    logic [c_WAIT_W-1:0]    r_wait;
    logic [2:0]             r_step;
    logic [3:0]             r_snap_p;       // {left, right, up, down}
    logic [3:0]             r_snap_b;       // {left, right, up, down}
    logic                   r_porb;
    logic                   r_pending;
    logic                   r_frame_start;
    logic                   r_overrun;
    logic                   r_timeout_err;

    logic                   w_tick;
    logic                   w_next_porb;
    logic                   w_start;
    logic                   w_timeout;
    logic                   w_in_dir;
    logic                   w_step_done;
    logic [3:0]             w_dir;
    logic                   w_en_left;
    logic                   w_en_right;
    logic                   w_en_up;
    logic                   w_en_down;
    state_t                 w_from_clear;
    state_t                 w_from_left;
    state_t                 w_from_right;
    state_t                 w_from_up;

    assign w_tick = (r_frame_cnt == c_FRAME_LAST);

    // Active object's snapshot; an opposing pair cancels both directions.
    assign w_dir      = r_porb ? r_snap_b : r_snap_p;
    assign w_en_left  = w_dir[3] & ~w_dir[2];
    assign w_en_right = w_dir[2] & ~w_dir[3];
    assign w_en_up    = w_dir[1] & ~w_dir[0];
    assign w_en_down  = w_dir[0] & ~w_dir[1];

    // Next move in LEFT, RIGHT, UP, DOWN order, skipping disabled ones.
    assign w_from_up    = w_en_down  ? S_DOWN  : S_DRAW;
    assign w_from_right = w_en_up    ? S_UP    : w_from_up;
    assign w_from_left  = w_en_right ? S_RIGHT : w_from_right;
    assign w_from_clear = w_en_left  ? S_LEFT  : w_from_left;

    assign w_in_dir    = (r_state == S_LEFT) || (r_state == S_RIGHT) ||
                         (r_state == S_UP)   || (r_state == S_DOWN);
    assign w_step_done = (r_step == (r_porb ? c_B_LAST : c_P_LAST));

    // Next-state and transition strobes.
    always_comb begin
        w_next_state = r_state;
        w_next_porb  = r_porb;
        w_start      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_PREHOLD: w_next_state = S_HOLD;
            S_HOLD: begin
                if (w_tick || r_pending) begin
                    w_next_state = S_CLEAR;
                    w_start      = 1'b1;
                    w_next_porb  = bird_active;
                end
            end
            S_CLEAR: begin
                if (done) begin
                    w_next_state = w_from_clear;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_next_state = S_HOLD;
                    w_timeout    = 1'b1;
                    w_next_porb  = 1'b0;
                end
            end
            S_LEFT:  if (w_step_done) w_next_state = w_from_left;
            S_RIGHT: if (w_step_done) w_next_state = w_from_right;
            S_UP:    if (w_step_done) w_next_state = w_from_up;
            S_DOWN:  if (w_step_done) w_next_state = S_DRAW;
            S_DRAW: begin
                if (done) begin
                    if (r_porb) begin
                        w_next_state = S_CLEAR;
                        w_next_porb  = 1'b0;
                    end else begin
                        w_next_state = S_HOLD;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_next_state = S_HOLD;
                    w_timeout    = 1'b1;
                    w_next_porb  = 1'b0;
                end
            end
            default: w_next_state = S_HOLD;
        endcase
    end

    // Free-running frame counter; wraps once per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_tick) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + c_FRAME_W'(1);
        end
    end

    // State, object select, snapshots and per-state wait/step counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_PREHOLD;
            r_porb        <= 1'b0;
            r_frame_start <= 1'b0;
            r_snap_p      <= '0;
            r_snap_b      <= '0;
            r_wait        <= '0;
            r_step        <= '0;
        end else begin
            r_state       <= w_next_state;
            r_porb        <= w_next_porb;
            r_frame_start <= w_start;
            if (w_start) begin
                r_snap_p <= {p_left, p_right, p_up, p_down};
                r_snap_b <= {b_left, b_right, b_up, b_down};
            end
            if (w_next_state != r_state) begin
                r_wait <= '0;
                r_step <= '0;
            end else begin
                if ((r_state == S_CLEAR) || (r_state == S_DRAW)) begin
                    r_wait <= r_wait + c_WAIT_W'(1);
                end
                if (w_in_dir) begin
                    r_step <= r_step + 3'd1;
                end
            end
        end
    end

    // One-deep tick queue plus sticky overrun and timeout flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending     <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_tick && (r_state != S_HOLD)) begin
                r_pending <= 1'b1;
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign control     = r_state;
    assign PorB        = r_porb;
    assign frame_start = r_frame_start;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_movement_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_movement_control
// Purpose  : Self-checking bench for movement_control. Expected control-code
//            sequences are queued per frame and compared as the DUT steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_movement_control;

    localparam int c_P_STEP = 2;
    localparam int c_B_STEP = 1;

    localparam logic [3:0] c_PREHOLD = 4'b0100;
    localparam logic [3:0] c_HOLD    = 4'b0000;
    localparam logic [3:0] c_CLEAR   = 4'b0001;
    localparam logic [3:0] c_LEFT    = 4'b0011;
    localparam logic [3:0] c_RIGHT   = 4'b0010;
    localparam logic [3:0] c_DOWN    = 4'b0110;
    localparam logic [3:0] c_UP      = 4'b0111;
    localparam logic [3:0] c_DRAW    = 4'b0101;

    logic       clk;
    logic       reset = 1'b1;
    logic       done = 1'b0;
    logic       p_left = 1'b0, p_right = 1'b0, p_up = 1'b0, p_down = 1'b0;
    logic       b_left = 1'b0, b_right = 1'b0, b_up = 1'b0, b_down = 1'b0;
    logic       bird_active = 1'b0;
    logic [3:0] control;
    logic       PorB;
    logic       frame_start;
    logic       overrun;
    logic       timeout_err;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cycle = 0;
    logic       monitor_en = 1'b1;
    logic       done_en = 1'b1;
    logic [4:0] exp_q[$];

    movement_control #(
        .FRAME_CYCLES (100),
        .P_STEP       (c_P_STEP),
        .B_STEP       (c_B_STEP),
        .TIMEOUT      (150)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .done        (done),
        .p_left      (p_left),
        .p_right     (p_right),
        .p_up        (p_up),
        .p_down      (p_down),
        .b_left      (b_left),
        .b_right     (b_right),
        .b_up        (b_up),
        .b_down      (b_down),
        .bird_active (bird_active),
        .control     (control),
        .PorB        (PorB),
        .frame_start (frame_start),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic is_dir(input logic [3:0] c);
        return (c == c_LEFT) || (c == c_RIGHT) || (c == c_UP) || (c == c_DOWN);
    endfunction

    // Expected codes for one object pass: CLEAR, enabled moves, DRAW.
    task automatic push_pass(input logic porb, input logic l, input logic r,
                             input logic u, input logic d);
        int n;
        n = porb ? c_B_STEP : c_P_STEP;
        exp_q.push_back({porb, c_CLEAR});
        if (l && !r) repeat (n) exp_q.push_back({porb, c_LEFT});
        if (r && !l) repeat (n) exp_q.push_back({porb, c_RIGHT});
        if (u && !d) repeat (n) exp_q.push_back({porb, c_UP});
        if (d && !u) repeat (n) exp_q.push_back({porb, c_DOWN});
        exp_q.push_back({porb, c_DRAW});
    endtask

    // Expected codes for a whole frame from the inputs as currently driven.
    task automatic push_frame();
        if (bird_active) push_pass(1'b1, b_left, b_right, b_up, b_down);
        push_pass(1'b0, p_left, p_right, p_up, p_down);
        exp_q.push_back({1'b0, c_HOLD});
    endtask

    task automatic wait_ctl(input string tag, input logic [3:0] code, input int bound);
        int n;
        n = 0;
        while (control !== code && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, control, code);
    endtask

    task automatic wait_start(output int cyc, input int bound);
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (!frame_start && cyc < bound);
    endtask

    // Datapath stand-in: done pulse 20 cycles after each CLEAR/DRAW entry.
    initial begin : p_done
        logic [4:0] last;
        int         cnt;
        last = {1'b0, c_PREHOLD};
        cnt  = 0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (!reset && (control == c_CLEAR || control == c_DRAW) && {PorB, control} != last) begin
                cnt = 19;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) done = done_en;
            end
            last = reset ? {1'b0, c_PREHOLD} : {PorB, control};
        end
    end

    // Scoreboard: each state entry and every direction cycle pops one item.
    initial begin : p_monitor
        logic [4:0] prev;
        logic [4:0] item;
        logic [4:0] want;
        prev = {1'b0, c_PREHOLD};
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = {1'b0, c_PREHOLD};
            end else begin
                item = {PorB, control};
                if (monitor_en && control != c_PREHOLD && (item != prev || is_dir(control)) &&
                    !(control == c_HOLD && prev[3:0] == c_PREHOLD)) begin
                    if (exp_q.size() == 0) begin
                        check("seq_extra_item", exp_q.size(), 1);
                    end else begin
                        want = exp_q.pop_front();
                        check("seq", item, want);
                    end
                end
                prev = item;
            end
        end
    end

    initial begin : p_stim
        int cyc;
        int t_prev;

        // Frame 1: bird moves right, player moves up.
        bird_active = 1'b1;
        b_right     = 1'b1;
        p_up        = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_control", control, c_PREHOLD);
        check("rst_porb", PorB, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        push_frame();

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("prehold_after_release", control, c_PREHOLD);
        @(negedge clk); #1;
        check("hold_after_prehold", control, c_HOLD);
        wait_start(cyc, 300);
        check("f1_start", frame_start, 1'b1);
        check("f1_start_cycle", cyc + 1, 100);
        t_prev = cycle;
        wait_ctl("f1_end", c_HOLD, 200);
        check("f1_queue", exp_q.size(), 0);

        // Frame 2: no bird, left+right cancel, player moves down.
        bird_active = 1'b0;
        b_right     = 1'b0;
        p_up        = 1'b0;
        p_left      = 1'b1;
        p_right     = 1'b1;
        p_down      = 1'b1;
        push_frame();
        wait_start(cyc, 300);
        check("f2_start", frame_start, 1'b1);
        check("f2_period", cycle - t_prev, 100);
        t_prev = cycle;
        wait_ctl("f2_draw", c_DRAW, 100);
        p_up   = 1'b1;
        p_down = 1'b0;
        wait_ctl("f2_end", c_HOLD, 100);
        check("f2_queue", exp_q.size(), 0);

        // Frame 3: request changed mid-frame 2 now takes effect.
        push_frame();
        wait_start(cyc, 300);
        check("f3_start", frame_start, 1'b1);
        check("f3_period", cycle - t_prev, 100);
        t_prev = cycle;
        wait_ctl("f3_end", c_HOLD, 100);
        check("f3_queue", exp_q.size(), 0);

        // Frame 4: done withheld -> timeout, pending restart, overrun.
        monitor_en  = 1'b0;
        done_en     = 1'b0;
        bird_active = 1'b1;
        b_left      = 1'b1;
        wait_start(cyc, 300);
        check("f4_start", frame_start, 1'b1);
        check("f4_period", cycle - t_prev, 100);
        check("f4_porb", PorB, 1'b1);
        check("timeout_before", timeout_err, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (control !== c_HOLD && cyc < 300);
        check("timeout_cycles", cyc, 150);
        check("timeout_flag", timeout_err, 1'b1);
        check("timeout_porb", PorB, 1'b0);
        check("overrun_before", overrun, 1'b0);
        @(negedge clk); #1;
        check("pending_restart", frame_start, 1'b1);
        check("pending_control", control, c_CLEAR);
        check("pending_porb", PorB, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (!overrun && cyc < 300);
        check("overrun_cycles", cyc, 149);
        check("overrun_flag", overrun, 1'b1);

        // Reset in the middle of the player UP moves.
        done_en     = 1'b1;
        bird_active = 1'b0;
        b_left      = 1'b0;
        wait_ctl("reach_up", c_UP, 100);
        #1 reset = 1'b1;
        #1;
        check("midrst_control", control, c_PREHOLD);
        check("midrst_porb", PorB, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_timeout", timeout_err, 1'b0);
        check("midrst_frame_start", frame_start, 1'b0);
        exp_q.delete();
        push_frame();
        @(negedge clk);
        reset = 1'b0;
        #1;
        monitor_en = 1'b1;
        wait_start(cyc, 300);
        check("resume_start", frame_start, 1'b1);
        check("resume_cycle", cyc, 100);
        wait_ctl("resume_end", c_HOLD, 100);
        check("resume_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
